// File: rtl/att_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | att_pkg                                                                |
// | Shared types for the address translation table: write-mode encoding,  |
// | table FSM states and the stored entry layout.                          |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package att_pkg;

   localparam int c_att_addr_w = 11;
   localparam int c_att_mask_w = 20;

   typedef enum logic [1:0] {
      WR_OVERWRITE = 2'd0,
      WR_MASK_SET  = 2'd1,
      WR_MASK_CLR  = 2'd2,
      WR_ADDR_ONLY = 2'd3
   } att_wr_mode_e;

   typedef enum logic [0:0] {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } att_state_e;

   typedef struct packed {
      logic [c_att_addr_w-1:0] address;
      logic [c_att_mask_w-1:0] mask;
   } att_entry_t;

endpackage
`default_nettype wire

// File: rtl/att_mask_update.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | att_mask_update                                                        |
// | Combinational merge of an existing table entry with write data        |
// | according to the write mode.                                           |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module att_mask_update
   import att_pkg::*;
(
   input  att_entry_t              i_old_entry,
   input  att_wr_mode_e            i_mode,
   input  logic [c_att_addr_w-1:0] i_wr_address,
   input  logic [c_att_mask_w-1:0] i_wr_mask,
   output att_entry_t              o_new_entry
);

   always_comb begin
      o_new_entry = i_old_entry;
      case (i_mode)
         WR_OVERWRITE: begin
            o_new_entry.address = i_wr_address;
            o_new_entry.mask    = i_wr_mask;
         end
         WR_MASK_SET:  o_new_entry.mask    = i_old_entry.mask | i_wr_mask;
         WR_MASK_CLR:  o_new_entry.mask    = i_old_entry.mask & ~i_wr_mask;
         WR_ADDR_ONLY: o_new_entry.address = i_wr_address;
         default:      o_new_entry = i_old_entry;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/address_translation_table_mp.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | address_translation_table_mp                                           |
// | Multi-read-port literal address/mask table with self-initialisation.  |
// | Define ATT_WR_BYPASS_EN to forward same-cycle writes to reads.         |
// | Entry widths track att_pkg (c_att_addr_w / c_att_mask_w).              |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module address_translation_table_mp
   import att_pkg::*;
#(
   parameter  int NV                       = 32,
   parameter  int LITERAL_ADDRESS_WIDTH    = c_att_addr_w,
   parameter  int MAX_CLAUSES_PER_VARIABLE = c_att_mask_w,
   parameter  int NUM_RD                   = 2,
   localparam int AT_SIZE                  = 2 * NV,
   localparam int IDX_W                    = $clog2(AT_SIZE)
)(
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic                                       clear_i,
   output logic                                       ready_o,
   input  logic                                       wr_en_i,
   input  logic [IDX_W-1:0]                           wr_index_i,
   input  logic [1:0]                                 wr_mode_i,
   input  logic [LITERAL_ADDRESS_WIDTH-1:0]           wr_address_i,
   input  logic [MAX_CLAUSES_PER_VARIABLE-1:0]        wr_mask_i,
   input  logic [NUM_RD-1:0]                          rd_en_i,
   input  logic [NUM_RD*IDX_W-1:0]                    rd_index_i,
   output logic [NUM_RD-1:0]                          rd_valid_o,
   output logic [NUM_RD*LITERAL_ADDRESS_WIDTH-1:0]    rd_address_o,
   output logic [NUM_RD*MAX_CLAUSES_PER_VARIABLE-1:0] rd_mask_o,
   output logic                                       err_o
);

   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(AT_SIZE - 1);

   att_state_e        r_state;
   att_state_e        w_state_next;
   logic [IDX_W-1:0]  r_init_cnt;
   att_entry_t        r_mem [AT_SIZE];
   logic              r_err;
   logic              w_ready;
   logic              w_clear;
   logic              w_wr_in_range;
   logic [NUM_RD-1:0] w_rd_in_range;
   logic              w_wr_commit;
   logic              w_err_set;
   att_entry_t        w_wr_old;
   att_entry_t        w_wr_new;

   // Range checks collapse to constants when the depth is a power of two.
   if (AT_SIZE == (1 << IDX_W)) begin : g_pow2
      assign w_wr_in_range = 1'b1;
      assign w_rd_in_range = '1;
   end else begin : g_npow2
      assign w_wr_in_range = ({1'b0, wr_index_i} < (IDX_W+1)'(AT_SIZE));
      for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_range
         assign w_rd_in_range[p] =
            ({1'b0, rd_index_i[p*IDX_W +: IDX_W]} < (IDX_W+1)'(AT_SIZE));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_INIT;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_INIT:  if (r_init_cnt == c_last_idx) w_state_next = ST_READY;
         ST_READY: if (clear_i) w_state_next = ST_INIT;
         default:  w_state_next = ST_INIT;
      endcase
   end

   always_comb begin
      w_ready = (r_state == ST_READY);
   end

   assign ready_o     = w_ready;
   assign w_clear     = w_ready & clear_i;
   assign w_wr_commit = ~reset & w_ready & wr_en_i & w_wr_in_range;
   assign w_err_set   = (~w_ready & (wr_en_i | (|rd_en_i)))
                      | (w_ready & wr_en_i & ~w_wr_in_range)
                      | (w_ready & (|(rd_en_i & ~w_rd_in_range)));

   always_ff @(posedge clk) begin
      if (reset)                      r_init_cnt <= '0;
      else if (r_state == ST_INIT &&
               r_init_cnt != c_last_idx) r_init_cnt <= r_init_cnt + IDX_W'(1);
      else                            r_init_cnt <= '0;
   end

   always_ff @(posedge clk) begin
      if (reset)          r_err <= 1'b0;
      else if (w_clear)   r_err <= 1'b0;
      else if (w_err_set) r_err <= 1'b1;
   end

   assign err_o    = r_err;
   assign w_wr_old = r_mem[wr_index_i];

   // One merge instance feeds both the array write and the read bypass.
   att_mask_update u_merge (
      .i_old_entry  (w_wr_old),
      .i_mode       (att_wr_mode_e'(wr_mode_i)),
      .i_wr_address (wr_address_i),
      .i_wr_mask    (wr_mask_i),
      .o_new_entry  (w_wr_new)
   );

   always_ff @(posedge clk) begin
      if (r_state == ST_INIT) r_mem[r_init_cnt] <= '0;
      else if (w_wr_commit)   r_mem[wr_index_i] <= w_wr_new;
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [IDX_W-1:0] w_idx;
      logic             w_accept;
      att_entry_t       w_data;
      logic             r_valid;
      att_entry_t       r_data;

      assign w_idx    = rd_index_i[p*IDX_W +: IDX_W];
      assign w_accept = w_ready & rd_en_i[p];

      always_comb begin
         w_data = '0;
         if (w_rd_in_range[p]) begin
            w_data = r_mem[w_idx];
`ifdef ATT_WR_BYPASS_EN
            if (w_wr_commit && (wr_index_i == w_idx)) w_data = w_wr_new;
`endif
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
         end else begin
            r_valid <= w_accept;
            r_data  <= w_accept ? w_data : '0;
         end
      end

      assign rd_valid_o[p] = r_valid;
      assign rd_address_o[p*LITERAL_ADDRESS_WIDTH +: LITERAL_ADDRESS_WIDTH] = r_data.address;
      assign rd_mask_o[p*MAX_CLAUSES_PER_VARIABLE +: MAX_CLAUSES_PER_VARIABLE] = r_data.mask;
   end

endmodule
`default_nettype wire

// File: tb/tb_address_translation_table_mp.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_address_translation_table_mp                                        |
// | Scoreboard bench for address_translation_table_mp (NV=32, NUM_RD=2).   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_address_translation_table_mp;

   logic        clk = 1'b0;
   logic        reset, clear_i, wr_en_i, ready_o, err_o;
   logic [5:0]  wr_index_i;
   logic [1:0]  wr_mode_i;
   logic [10:0] wr_address_i;
   logic [19:0] wr_mask_i;
   logic [1:0]  rd_en_i, rd_valid_o;
   logic [11:0] rd_index_i;
   logic [21:0] rd_address_o;
   logic [39:0] rd_mask_o;

   address_translation_table_mp dut (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (clear_i),
      .ready_o      (ready_o),
      .wr_en_i      (wr_en_i),
      .wr_index_i   (wr_index_i),
      .wr_mode_i    (wr_mode_i),
      .wr_address_i (wr_address_i),
      .wr_mask_i    (wr_mask_i),
      .rd_en_i      (rd_en_i),
      .rd_index_i   (rd_index_i),
      .rd_valid_o   (rd_valid_o),
      .rd_address_o (rd_address_o),
      .rd_mask_o    (rd_mask_o),
      .err_o        (err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r;
      logic        e;
      logic [1:0]  v;
      logic [10:0] a [2];
      logic [19:0] k [2];
   } exp_t;

   exp_t        sb_q [$];
   int          n_checks = 0;
   int          n_fail   = 0;

   // stimulus for the next cycle
   logic        s_rst = 1'b1, s_clr = 1'b0, s_wen = 1'b0;
   logic [5:0]  s_widx = '0;
   logic [1:0]  s_mode = '0;
   logic [10:0] s_waddr = '0;
   logic [19:0] s_wmask = '0;
   logic [1:0]  s_ren = '0;
   logic [5:0]  s_ridx [2] = '{6'd0, 6'd0};

   // reference model
   logic        m_ready = 1'b0, m_err = 1'b0;
   int          m_cnt = 0;
   logic [10:0] m_addr [64];
   logic [19:0] m_mask [64];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [30:0] merged(input int idx);
      logic [10:0] a;
      logic [19:0] k;
      a = m_addr[idx];
      k = m_mask[idx];
      case (s_mode)
         2'd0: begin a = s_waddr; k = s_wmask; end
         2'd1: k = k | s_wmask;
         2'd2: k = k & ~s_wmask;
         default: a = s_waddr;
      endcase
      return {a, k};
   endfunction

   task automatic step();
      exp_t        e;
      logic [30:0] nw;
      @(negedge clk);
      reset        = s_rst;
      clear_i      = s_clr;
      wr_en_i      = s_wen;
      wr_index_i   = s_widx;
      wr_mode_i    = s_mode;
      wr_address_i = s_waddr;
      wr_mask_i    = s_wmask;
      rd_en_i      = s_ren;
      rd_index_i   = {s_ridx[1], s_ridx[0]};
      e.v = 2'b00;
      e.a = '{11'd0, 11'd0};
      e.k = '{20'd0, 20'd0};
      if (s_rst) begin
         m_ready = 1'b0; m_cnt = 0; m_err = 1'b0;
      end else if (m_ready) begin
         for (int p = 0; p < 2; p++) begin
            if (s_ren[p]) begin
               e.v[p] = 1'b1;
               e.a[p] = m_addr[s_ridx[p]];
               e.k[p] = m_mask[s_ridx[p]];
`ifdef ATT_WR_BYPASS_EN
               if (s_wen && s_widx == s_ridx[p]) {e.a[p], e.k[p]} = merged(int'(s_ridx[p]));
`endif
            end
         end
         if (s_wen) begin
            nw = merged(int'(s_widx));
            {m_addr[s_widx], m_mask[s_widx]} = nw;
         end
         if (s_clr) begin
            m_err = 1'b0; m_ready = 1'b0; m_cnt = 0;
         end
      end else begin
         if (s_wen || s_ren != 2'b00) m_err = 1'b1;
         m_addr[m_cnt] = '0;
         m_mask[m_cnt] = '0;
         if (m_cnt == 63) begin m_ready = 1'b1; m_cnt = 0; end
         else m_cnt++;
      end
      e.r = m_ready;
      e.e = m_err;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk("ready", 32'(ready_o), 32'(e.r));
      chk("err", 32'(err_o), 32'(e.e));
      for (int p = 0; p < 2; p++) begin
         chk($sformatf("valid%0d", p), 32'(rd_valid_o[p]), 32'(e.v[p]));
         if (e.v[p]) begin
            chk($sformatf("addr%0d", p), 32'(rd_address_o[p*11 +: 11]), 32'(e.a[p]));
            chk($sformatf("mask%0d", p), 32'(rd_mask_o[p*20 +: 20]), 32'(e.k[p]));
         end
      end
      s_wen = 1'b0; s_ren = 2'b00; s_clr = 1'b0;
   endtask

   task automatic set_wr(input int idx, input int mode, input int addr, input int mask);
      s_wen = 1'b1; s_widx = 6'(idx); s_mode = 2'(mode);
      s_waddr = 11'(addr); s_wmask = 20'(mask);
   endtask

   task automatic set_rd(input logic [1:0] en, input int i0, input int i1);
      s_ren = en; s_ridx[0] = 6'(i0); s_ridx[1] = 6'(i1);
   endtask

   task automatic wait_ready(input string tag);
      int lat;
      lat = 0;
      do begin
         if (lat < 3 && !s_rst) set_rd(2'b11, lat, 63 - lat);
         step();
         lat++;
      end while (!ready_o && lat < 200);
      chk(tag, 32'(lat), 32'd64);
   endtask

   task automatic read_all();
      for (int i = 0; i < 64; i += 2) begin
         set_rd(2'b11, i, i + 1);
         step();
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin m_addr[i] = '0; m_mask[i] = '0; end
      repeat (3) step();
      chk("rst_addr", 32'(rd_address_o), 32'd0);
      chk("rst_mask", 32'(rd_mask_o[39:20] | rd_mask_o[19:0]), 32'd0);
      s_rst = 1'b0;
      wait_ready("init_latency");
      s_clr = 1'b0;
      read_all();

      set_wr(5, 0, 'h2A, 'h0000F); step();
      set_rd(2'b11, 5, 5); step();
      set_wr(5, 1, 0, 'hF0000); step();
      set_wr(5, 2, 0, 'h00003); step();
      set_rd(2'b11, 5, 5); step();
      chk("mask5_lit", 32'(rd_mask_o[19:0]), 32'h000F000C);
      chk("addr5_lit", 32'(rd_address_o[21:11]), 32'h2A);
      set_wr(5, 3, 'h7FF, 'hFFFFF); step();
      set_rd(2'b11, 5, 4); step();
      chk("mask5_keep", 32'(rd_mask_o[19:0]), 32'h000F000C);

      set_wr(9, 0, 'h33, 'h00055); step();
      set_wr(9, 0, 'h11, 'h000AA); set_rd(2'b11, 9, 9); step();
`ifdef ATT_WR_BYPASS_EN
      chk("collide_lit", 32'(rd_address_o[10:0]), 32'h11);
`else
      chk("collide_lit", 32'(rd_address_o[10:0]), 32'h33);
`endif
      set_rd(2'b11, 9, 5); step();
      set_wr(63, 0, 'h155, 'hABCDE); step();
      set_wr(0, 0, 'h001, 'h00001); set_rd(2'b11, 63, 0); step();
      set_rd(2'b11, 0, 63); step();

      s_clr = 1'b1;
      step();
      wait_ready("clear_latency");
      read_all();

      s_clr = 1'b1;
      step();
      repeat (30) step();
      s_rst = 1'b1;
      step();
      s_rst = 1'b0;
      wait_ready("reset_mid_init_latency");
      read_all();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/address_translation_table_mp.md
ADDRESS_TRANSLATION_TABLE_MP -- requirements
Module: address_translation_table_mp

Interface
REQ-001 SHALL have parameter NV, default 32, number of variables; table depth AT_SIZE = 2*NV (LSB of index = negation bit).
REQ-002 SHALL have parameter LITERAL_ADDRESS_WIDTH, default 11, width of the address field.
REQ-003 SHALL have parameter MAX_CLAUSES_PER_VARIABLE, default 20, width of the mask field.
REQ-004 SHALL have parameter NUM_RD, default 2, number of independent read ports; IDX_W = $clog2(AT_SIZE) is derived, not overridable.
REQ-005 SHALL have port clk input 1: the single clock; all logic on rising edge.
REQ-006 SHALL have port reset input 1: synchronous, active-high reset.
REQ-007 SHALL have port clear_i input 1: request re-initialisation of the whole table.
REQ-008 SHALL have port ready_o output 1: table initialised and accepting reads/writes.
REQ-009 SHALL have port wr_en_i input 1; wr_index_i input IDX_W; wr_mode_i input 2 (0 overwrite, 1 mask OR-set, 2 mask AND-clear, 3 address-only); wr_address_i input LITERAL_ADDRESS_WIDTH; wr_mask_i input MAX_CLAUSES_PER_VARIABLE.
REQ-010 SHALL have port rd_en_i input NUM_RD and rd_index_i input NUM_RD*IDX_W (port p in slice p).
REQ-011 SHALL have ports rd_valid_o output NUM_RD, rd_address_o output NUM_RD*LITERAL_ADDRESS_WIDTH, rd_mask_o output NUM_RD*MAX_CLAUSES_PER_VARIABLE.
REQ-012 SHALL have port err_o output 1: sticky flag, out-of-range index or access while not ready.

Function
REQ-013 SHALL implement FSM INIT -> READY; INIT writes entry k = {address=0, mask=0} for k = 0..AT_SIZE-1, one per cycle, then enters READY; ready_o = (state==READY), registered.
REQ-014 SHALL take exactly AT_SIZE cycles from reset deassertion to ready_o=1.
REQ-015 SHALL, on clear_i in READY, return to INIT with counter 0 the next cycle; clear_i in INIT is ignored.
REQ-016 SHALL give reads latency 1: rd_en_i[p] sampled at edge N -> rd_valid_o[p]=1 and data valid after edge N+1, held for one cycle only; rd_valid_o[p]=0 otherwise.
REQ-017 SHALL serve all NUM_RD ports in the same cycle, including identical indices.
REQ-018 SHALL commit writes at the sampling edge; mode 0 replaces both fields, mode 1 mask|=wr_mask_i, mode 2 mask&=~wr_mask_i, mode 3 replaces address, mask unchanged.
REQ-019 SHALL treat index >= AT_SIZE (only possible when AT_SIZE not a power of 2) as out of range: write dropped, read returns zeros with rd_valid_o=1, err_o set.
REQ-020 SHALL drop reads and writes while ready_o=0 (rd_valid_o stays 0) and set err_o.
REQ-021 SHALL, on read and write to same index in the same cycle, return data per REQ-029.
REQ-022 SHALL clear err_o only by reset or clear_i.

Reset
REQ-023 SHALL on reset drive ready_o=0, rd_valid_o=0, rd_address_o=0, rd_mask_o=0, err_o=0, state=INIT, counter=0.
REQ-024 SHALL, on reset asserted mid-INIT or mid-operation, restart INIT from entry 0; reset has priority over clear_i and writes.
REQ-025 SHALL not rely on reset of the storage array; INIT clears it.

Configuration
REQ-026 SHALL use macro ATT_WR_BYPASS_EN.
REQ-027 SHALL, with ATT_WR_BYPASS_EN defined, forward the same-cycle write (post-mode result) to colliding reads.
REQ-028 SHALL, without it, return pre-write contents to colliding reads.
REQ-029 SHALL implement exactly one of REQ-027/REQ-028 per build.

Structure
REQ-030 SHALL place wr_mode encoding enum, FSM state typedef and entry struct (address, mask) in package att_pkg.
REQ-031 SHALL use one sub-module att_mask_update (combinational mode merge of old entry and write data), shared by write and bypass paths.

Verification (defaults NV=32, AT_SIZE=64, NUM_RD=2)
REQ-032 SHALL check reset release -> ready_o rises after exactly 64 cycles; read of every index returns address=0, mask=0.
REQ-033 SHALL check write idx 5 mode0 addr=0x2A mask=0x0000F; next cycle read both ports idx 5 -> both valid, addr=0x2A, mask=0x0000F.
REQ-034 SHALL check mode1 mask=0xF0000 then mode2 mask=0x00003 on idx 5 -> mask=0xF000C, addr=0x2A; mode3 addr=0x7FF -> mask unchanged.
REQ-035 SHALL check same-cycle write idx 9 addr=0x11 and read idx 9 -> 0x11 with ATT_WR_BYPASS_EN, previous value without.
REQ-036 SHALL check clear_i after writes -> ready_o low 64 cycles, reads during INIT give rd_valid_o=0 and err_o=1, all entries zero afterwards.
REQ-037 SHALL check reset asserted at INIT count 30 -> ready_o rises 64 cycles after release.
